k423_id_scoreboard: RTL and testbench
=====================================

Name: k423_id_scoreboard

Overview:
- Issue controller between the ID-stage decoder and the EX-stage units.
- Tracks destination registers of long-latency ops (MDU, LSU load) in a per-register pending scoreboard and stalls RAW/WAW-hazarded instructions.
- Limits the MDU to one op in flight and caps outstanding loads.
- Provides the valid/ready handshake from ID to EX.

Parameters:
- REG_NUM, 32, number of architectural integer registers; x0 is never pending.
- LOAD_OS_MAX, 2, maximum outstanding loads, range 1..7.
- LOAD_CNT_W, 3, width of the outstanding-load counter; must hold LOAD_OS_MAX.

Ports:
- clk_i  in  1  core clock
- rst_n_i  in  1  asynchronous active-low reset
- id_vld_i  in  1  decoded instruction valid in ID
- id_rdy_o  out  1  ID may advance; high when ~id_vld_i or the issue fires
- dec_grp_i  in  `INST_GRP_W  one-hot group from decode (ALU/MDU/LSU/BJU/CSR)
- dec_lsu_load_i  in  1  instruction is a load
- dec_rs1_vld_i / dec_rs2_vld_i  in  1 each  source operand used
- dec_rs1_idx_i / dec_rs2_idx_i  in  `INST_RSDIDX_W each  source index
- dec_rd_vld_i  in  1  destination written
- dec_rd_idx_i  in  `INST_RSDIDX_W  destination index
- ex_rdy_i  in  1  EX accepts an instruction
- issue_vld_o  out  1  instruction issued to EX this cycle
- flush_i  in  1  pipeline flush (branch/exception)
- wb_vld_i  in  1  long-latency writeback valid
- wb_idx_i  in  `INST_RSDIDX_W  writeback register index
- mdu_done_i  in  1  MDU finished current op
- load_done_i  in  1  one load completed
- mdu_busy_o  out  1  MDU op in flight
- load_cnt_o  out  LOAD_CNT_W  outstanding loads
- pending_o  out  REG_NUM  scoreboard bit vector

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous, active-low (rst_n_i).
- Reset values: pending=0, mdu_busy=0, load_cnt=0. issue_vld_o=0 and id_rdy_o=1 while id_vld_i=0.
- Long-latency op (ll): MDU group, or LSU group with dec_lsu_load_i=1.
- Hazard terms use registered state only:
  - raw = rs1_vld & pending[rs1] | rs2_vld & pending[rs2]
  - waw = rd_vld & pending[rd]
  - struct = MDU & mdu_busy | load & (load_cnt == LOAD_OS_MAX)
- issue_vld_o = id_vld_i & ~flush_i & ~raw & ~waw & ~struct. Combinational, zero latency.
- fire = issue_vld_o & ex_rdy_i. id_rdy_o = ~id_vld_i | fire.
- On fire with ll & rd_vld & rd != 0: set pending[rd] at the next edge.
- On wb_vld_i: clear pending[wb_idx] at the next edge. wb to index 0 or to a non-pending index is a no-op.
- Set and clear of the same index in one cycle cannot occur without the optional feature, because waw blocks issue. With the feature, set wins.
- mdu_busy: set on MDU fire, cleared on mdu_done_i. Same-cycle set and clear gives 1, because a fire needs busy=0 and the done belongs to the prior op.
- load_cnt:
  - +1 on load fire, -1 on load_done_i; both in one cycle leaves it unchanged.
  - load_done_i at 0 is ignored (saturates) and flagged by a simulation assertion.
- flush_i: forces issue_vld_o=0 that cycle. Pending bits, mdu_busy and load_cnt are preserved, because in-flight ops still write back or complete.
- Stalled instructions are held by ID; this block holds no instruction state.
- Reset asserted mid-operation clears all state immediately. Later wb/done pulses for pre-reset ops are no-ops.

Optional Feature:
- Macro: K423_SB_WB_BYPASS_EN.
- Defined:
  - The same-cycle wb_vld_i/wb_idx_i clear is bypassed into raw/waw, so a dependent instruction issues in the writeback cycle.
  - mdu_done_i and load_done_i likewise bypass into struct.
  - Set wins over clear on an index collision.
- Undefined: hazards use registered state only, adding one stall cycle after writeback.

Test Plan:
- Independent ALU stream, ex_rdy_i=1 -> issue_vld_o=1 every cycle, pending stays 0.
- Load x5 fires, next instr add x6,x5,x1 -> stalled until wb_vld_i with idx 5. Issues 1 cycle after wb without the macro, in the wb cycle with it.
- MDU to x7 in flight, second MDU to x8 -> held while mdu_busy_o=1. Issues the cycle after mdu_done_i, or the same cycle with the macro.
- LOAD_OS_MAX=2: three back-to-back loads to x1,x2,x3 -> third stalls with load_cnt_o=2. Issues after load_done_i; load_done_i in the same cycle as a load fire keeps the count at 2.
- Load to x0 -> pending_o stays 0. wb_vld_i with idx 0 -> no change.
- flush_i during a valid non-hazard instr -> issue_vld_o=0, pending_o unchanged. rst_n_i low mid-load -> pending_o=0 and load_cnt_o=0 immediately.

Source files
------------

// File: rtl/k423_id_scoreboard.sv
// k423_id_scoreboard
// ID->EX issue controller. Holds a per-register pending scoreboard for
// long-latency destinations (MDU ops and loads), a single-entry MDU busy
// flag and an outstanding-load counter. It stalls RAW/WAW/structural
// hazards and provides the ID/EX valid/ready handshake.
//
// Optional build macro: K423_SB_WB_BYPASS_EN
//   defined   -> same-cycle writeback/done pulses are folded into the
//                hazard terms, so a dependent instruction issues in the
//                writeback cycle.
//   undefined -> hazards look at registered state only (one extra stall
//                cycle after writeback).

`ifndef INST_GRP_W
`define INST_GRP_W 5
`endif
`ifndef INST_RSDIDX_W
`define INST_RSDIDX_W 5
`endif

module k423_id_scoreboard #(
    parameter int REG_NUM     = 32,
    parameter int LOAD_OS_MAX = 2,
    parameter int LOAD_CNT_W  = 3
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      id_vld_i,
    output logic                      id_rdy_o,
    input  logic [`INST_GRP_W-1:0]    dec_grp_i,
    input  logic                      dec_lsu_load_i,
    input  logic                      dec_rs1_vld_i,
    input  logic                      dec_rs2_vld_i,
    input  logic [`INST_RSDIDX_W-1:0] dec_rs1_idx_i,
    input  logic [`INST_RSDIDX_W-1:0] dec_rs2_idx_i,
    input  logic                      dec_rd_vld_i,
    input  logic [`INST_RSDIDX_W-1:0] dec_rd_idx_i,
    input  logic                      ex_rdy_i,
    output logic                      issue_vld_o,
    input  logic                      flush_i,
    input  logic                      wb_vld_i,
    input  logic [`INST_RSDIDX_W-1:0] wb_idx_i,
    input  logic                      mdu_done_i,
    input  logic                      load_done_i,
    output logic                      mdu_busy_o,
    output logic [LOAD_CNT_W-1:0]     load_cnt_o,
    output logic [REG_NUM-1:0]        pending_o
);

    localparam int IDX_W   = `INST_RSDIDX_W;
    // One-hot group bit positions: ALU=0, MDU=1, LSU=2, BJU=3, CSR=4.
    localparam int GRP_MDU = 1;
    localparam int GRP_LSU = 2;
    localparam logic [LOAD_CNT_W-1:0] LOAD_MAX = LOAD_CNT_W'(LOAD_OS_MAX);

    logic [REG_NUM-1:0]    r_pending;
    logic                  r_mdu_busy;
    logic [LOAD_CNT_W-1:0] r_load_cnt;

    logic                  w_is_mdu;
    logic                  w_is_load;
    logic                  w_is_ll;
    logic [REG_NUM-1:0]    w_clr_mask;
    logic [REG_NUM-1:0]    w_set_mask;
    logic [REG_NUM-1:0]    w_pend_eff;
    logic                  w_mdu_busy_eff;
    logic [LOAD_CNT_W-1:0] w_load_cnt_eff;
    logic                  w_load_dec;
    logic                  w_raw;
    logic                  w_waw;
    logic                  w_struct;
    logic                  w_issue;
    logic                  w_fire;
    logic                  w_unused_grp;

    assign w_is_mdu     = dec_grp_i[GRP_MDU];
    assign w_is_load    = dec_grp_i[GRP_LSU] & dec_lsu_load_i;
    assign w_is_ll      = w_is_mdu | w_is_load;
    assign w_unused_grp = ^{dec_grp_i[0], dec_grp_i[`INST_GRP_W-1:3]};

    // A done pulse with nothing outstanding is ignored so the counter never wraps.
    assign w_load_dec = load_done_i & (r_load_cnt != '0);

    // Per-register set/clear masks; x0 never sets.
    generate
        for (genvar gi = 0; gi < REG_NUM; gi++) begin : g_mask
            assign w_clr_mask[gi] = wb_vld_i & (wb_idx_i == IDX_W'(gi));
            if (gi == 0) begin : g_x0
                assign w_set_mask[gi] = 1'b0;
            end else begin : g_xn
                assign w_set_mask[gi] = w_fire & w_is_ll & dec_rd_vld_i &
                                        (dec_rd_idx_i == IDX_W'(gi));
            end
        end
    endgenerate

`ifdef K423_SB_WB_BYPASS_EN
    assign w_pend_eff     = r_pending & ~w_clr_mask;
    assign w_mdu_busy_eff = r_mdu_busy & ~mdu_done_i;
    assign w_load_cnt_eff = r_load_cnt - LOAD_CNT_W'(w_load_dec);
`else
    assign w_pend_eff     = r_pending;
    assign w_mdu_busy_eff = r_mdu_busy;
    assign w_load_cnt_eff = r_load_cnt;
`endif

    // Hazard detection and the ID/EX handshake.
    always_comb begin
        w_raw    = (dec_rs1_vld_i & w_pend_eff[dec_rs1_idx_i]) |
                   (dec_rs2_vld_i & w_pend_eff[dec_rs2_idx_i]);
        w_waw    = dec_rd_vld_i & w_pend_eff[dec_rd_idx_i];
        w_struct = (w_is_mdu & w_mdu_busy_eff) |
                   (w_is_load & (w_load_cnt_eff == LOAD_MAX));
        w_issue  = id_vld_i & ~flush_i & ~w_raw & ~w_waw & ~w_struct;
        w_fire   = w_issue & ex_rdy_i;
    end

    assign issue_vld_o = w_issue;
    assign id_rdy_o    = ~id_vld_i | w_fire;

    // Scoreboard: a new long-latency destination wins over a same-index writeback.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_set_mask | (r_pending & ~w_clr_mask);
        end
    end

    // MDU busy: a fire can only happen while idle, so a same-cycle done belongs to the old op.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_mdu_busy <= 1'b0;
        end else if (w_fire & w_is_mdu) begin
            r_mdu_busy <= 1'b1;
        end else if (mdu_done_i) begin
            r_mdu_busy <= 1'b0;
        end
    end

    // Outstanding-load counter: increment on load fire, decrement on completion.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_load_cnt <= '0;
        end else begin
            case ({w_fire & w_is_load, w_load_dec})
                2'b10:   r_load_cnt <= r_load_cnt + LOAD_CNT_W'(1);
                2'b01:   r_load_cnt <= r_load_cnt - LOAD_CNT_W'(1);
                default: r_load_cnt <= r_load_cnt;
            endcase
        end
    end

    // A load completion reported with no load outstanding indicates an upstream bug.
    a_load_done_underflow: assert property (
        @(posedge clk_i) disable iff (!rst_n_i) !(load_done_i && (r_load_cnt == '0))
    );

    assign mdu_busy_o = r_mdu_busy;
    assign load_cnt_o = r_load_cnt;
    assign pending_o  = r_pending;

endmodule

// File: tb/tb_k423_id_scoreboard.sv
// Directed bench for k423_id_scoreboard (REG_NUM=32, LOAD_OS_MAX=2).
// Inputs change 1 time unit after the rising edge; outputs are sampled a
// further unit later, well clear of the next edge.
module tb_k423_id_scoreboard;

`ifdef K423_SB_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam logic [4:0] G_ALU = 5'b00001;
    localparam logic [4:0] G_MDU = 5'b00010;
    localparam logic [4:0] G_LSU = 5'b00100;

    logic        clk, rst_n;
    logic        id_vld, id_rdy;
    logic [4:0]  grp;
    logic        is_load;
    logic        rs1_vld, rs2_vld, rd_vld;
    logic [4:0]  rs1_idx, rs2_idx, rd_idx;
    logic        ex_rdy, issue_vld, flush;
    logic        wb_vld;
    logic [4:0]  wb_idx;
    logic        mdu_done, load_done, mdu_busy;
    logic [2:0]  load_cnt;
    logic [31:0] pending;

    int total = 0;
    int bad   = 0;
    int exp_cnt;

    k423_id_scoreboard #(.REG_NUM(32), .LOAD_OS_MAX(2), .LOAD_CNT_W(3)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .id_vld_i(id_vld), .id_rdy_o(id_rdy),
        .dec_grp_i(grp), .dec_lsu_load_i(is_load),
        .dec_rs1_vld_i(rs1_vld), .dec_rs2_vld_i(rs2_vld),
        .dec_rs1_idx_i(rs1_idx), .dec_rs2_idx_i(rs2_idx),
        .dec_rd_vld_i(rd_vld), .dec_rd_idx_i(rd_idx),
        .ex_rdy_i(ex_rdy), .issue_vld_o(issue_vld), .flush_i(flush),
        .wb_vld_i(wb_vld), .wb_idx_i(wb_idx),
        .mdu_done_i(mdu_done), .load_done_i(load_done),
        .mdu_busy_o(mdu_busy), .load_cnt_o(load_cnt), .pending_o(pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [4:0] g, input logic ld,
                         input logic r1v, input logic [4:0] r1,
                         input logic r2v, input logic [4:0] r2,
                         input logic rdv, input logic [4:0] rd);
        id_vld = 1'b1; grp = g; is_load = ld;
        rs1_vld = r1v; rs1_idx = r1; rs2_vld = r2v; rs2_idx = r2;
        rd_vld = rdv; rd_idx = rd;
    endtask

    task automatic idle();
        id_vld = 1'b0; grp = G_ALU; is_load = 1'b0;
        rs1_vld = 1'b0; rs2_vld = 1'b0; rd_vld = 1'b0;
        rs1_idx = '0; rs2_idx = '0; rd_idx = '0;
    endtask

    initial begin
        rst_n = 1'b0; ex_rdy = 1'b1; flush = 1'b0;
        wb_vld = 1'b0; wb_idx = '0; mdu_done = 1'b0; load_done = 1'b0;
        idle();
        #3;
        chk("rst_pending", pending, 32'h0);
        chk("rst_mdu_busy", mdu_busy, 1'b0);
        chk("rst_load_cnt", load_cnt, 3'd0);
        chk("rst_issue", issue_vld, 1'b0);
        chk("rst_id_rdy", id_rdy, 1'b1);
        tick();
        rst_n = 1'b1;
        tick();

        // Independent ALU stream
        for (int i = 0; i < 3; i++) begin
            instr(G_ALU, 1'b0, 1'b1, 5'(i + 1), 1'b1, 5'(i + 2), 1'b1, 5'(i + 10));
            #1;
            chk("alu_issue", issue_vld, 1'b1);
            chk("alu_id_rdy", id_rdy, 1'b1);
            tick();
            chk("alu_pending", pending, 32'h0);
        end

        // EX not ready: issue valid but no fire, no state change
        ex_rdy = 1'b0;
        instr(G_LSU, 1'b1, 1'b1, 5'd1, 1'b0, 5'd0, 1'b1, 5'd20);
        #1;
        chk("exnrdy_issue", issue_vld, 1'b1);
        chk("exnrdy_id_rdy", id_rdy, 1'b0);
        tick();
        chk("exnrdy_pending", pending, 32'h0);
        chk("exnrdy_cnt", load_cnt, 3'd0);
        ex_rdy = 1'b1;

        // Load x5 then add x6,x5,x1 (RAW)
        instr(G_LSU, 1'b1, 1'b1, 5'd1, 1'b0, 5'd0, 1'b1, 5'd5);
        #1;
        chk("ldx5_issue", issue_vld, 1'b1);
        tick();
        chk("ldx5_pending", pending, 32'h20);
        chk("ldx5_cnt", load_cnt, 3'd1);
        instr(G_ALU, 1'b0, 1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6);
        #1;
        chk("raw_stall", issue_vld, 1'b0);
        chk("raw_id_rdy", id_rdy, 1'b0);
        tick();
        chk("raw_stall2", issue_vld, 1'b0);
        wb_vld = 1'b1; wb_idx = 5'd5; load_done = 1'b1;
        #1;
        chk("raw_wb_cycle", issue_vld, BYP);
        tick();
        wb_vld = 1'b0; load_done = 1'b0;
        if (!BYP) begin
            #1;
            chk("raw_after_wb", issue_vld, 1'b1);
            tick();
        end
        idle();
        chk("raw_pending_clr", pending, 32'h0);
        chk("raw_cnt_clr", load_cnt, 3'd0);

        // MDU x7 in flight, second MDU x8 held
        instr(G_MDU, 1'b0, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 5'd7);
        #1;
        chk("mdu7_issue", issue_vld, 1'b1);
        tick();
        chk("mdu7_busy", mdu_busy, 1'b1);
        chk("mdu7_pending", pending, 32'h80);
        instr(G_MDU, 1'b0, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 5'd8);
        #1;
        chk("mdu8_held", issue_vld, 1'b0);
        tick();
        chk("mdu8_held2", issue_vld, 1'b0);
        mdu_done = 1'b1; wb_vld = 1'b1; wb_idx = 5'd7;
        #1;
        chk("mdu8_done_cycle", issue_vld, BYP);
        tick();
        mdu_done = 1'b0; wb_vld = 1'b0;
        if (BYP) begin
            chk("mdu_set_wins", mdu_busy, 1'b1);
        end else begin
            chk("mdu_busy_clr", mdu_busy, 1'b0);
            chk("mdu_pending_clr", pending, 32'h0);
            #1;
            chk("mdu8_after_done", issue_vld, 1'b1);
            tick();
            chk("mdu8_busy", mdu_busy, 1'b1);
        end
        chk("mdu8_pending", pending, 32'h100);
        idle();
        mdu_done = 1'b1; wb_vld = 1'b1; wb_idx = 5'd8;
        tick();
        mdu_done = 1'b0; wb_vld = 1'b0;
        chk("mdu8_busy_clr", mdu_busy, 1'b0);
        chk("mdu8_pending_clr", pending, 32'h0);

        // Three loads x1,x2,x3 with LOAD_OS_MAX=2
        instr(G_LSU, 1'b1, 1'b1, 5'd10, 1'b0, 5'd0, 1'b1, 5'd1);
        tick();
        instr(G_LSU, 1'b1, 1'b1, 5'd10, 1'b0, 5'd0, 1'b1, 5'd2);
        #1;
        chk("ld2_issue", issue_vld, 1'b1);
        tick();
        chk("ld2_cnt", load_cnt, 3'd2);
        chk("ld2_pending", pending, 32'h6);
        instr(G_LSU, 1'b1, 1'b1, 5'd10, 1'b0, 5'd0, 1'b1, 5'd3);
        #1;
        chk("ld3_stall", issue_vld, 1'b0);
        tick();
        chk("ld3_stall_cnt", load_cnt, 3'd2);
        load_done = 1'b1;
        #1;
        chk("ld3_done_cycle", issue_vld, BYP);
        tick();
        if (BYP) begin
            chk("ld3_cnt_keep2", load_cnt, 3'd2);
            exp_cnt = 2;
        end else begin
            chk("ld3_cnt_dec", load_cnt, 3'd1);
            // load x3 fires together with another completion: count holds
            #1;
            chk("ld3_issue", issue_vld, 1'b1);
            tick();
            chk("ld3_cnt_keep1", load_cnt, 3'd1);
            exp_cnt = 1;
        end
        load_done = 1'b0;
        idle();
        chk("ld3_pending", pending, 32'he);
        while (exp_cnt > 0) begin
            load_done = 1'b1;
            tick();
            exp_cnt--;
            chk("ld_drain_cnt", load_cnt, 3'(exp_cnt));
        end
        load_done = 1'b0;
        for (int r = 1; r <= 3; r++) begin
            wb_vld = 1'b1; wb_idx = 5'(r);
            tick();
        end
        wb_vld = 1'b0;
        chk("ld_pending_clr", pending, 32'h0);

        // Load to x0, wb to x0 and to a non-pending index
        instr(G_LSU, 1'b1, 1'b1, 5'd4, 1'b0, 5'd0, 1'b1, 5'd0);
        #1;
        chk("ldx0_issue", issue_vld, 1'b1);
        tick();
        idle();
        chk("ldx0_pending", pending, 32'h0);
        chk("ldx0_cnt", load_cnt, 3'd1);
        wb_vld = 1'b1; wb_idx = 5'd0; load_done = 1'b1;
        tick();
        wb_idx = 5'd9; load_done = 1'b0;
        tick();
        wb_vld = 1'b0;
        chk("wbx0_pending", pending, 32'h0);
        chk("ldx0_cnt_clr", load_cnt, 3'd0);

        // Flush with state in flight
        instr(G_LSU, 1'b1, 1'b1, 5'd1, 1'b0, 5'd0, 1'b1, 5'd12);
        tick();
        instr(G_MDU, 1'b0, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd14);
        tick();
        chk("pre_flush_pending", pending, 32'h5000);
        instr(G_LSU, 1'b1, 1'b1, 5'd1, 1'b0, 5'd0, 1'b1, 5'd13);
        flush = 1'b1;
        #1;
        chk("flush_issue", issue_vld, 1'b0);
        chk("flush_id_rdy", id_rdy, 1'b0);
        tick();
        flush = 1'b0;
        idle();
        chk("flush_pending", pending, 32'h5000);
        chk("flush_cnt", load_cnt, 3'd1);
        chk("flush_busy", mdu_busy, 1'b1);

        // Asynchronous reset mid-operation
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_pending", pending, 32'h0);
        chk("arst_cnt", load_cnt, 3'd0);
        chk("arst_busy", mdu_busy, 1'b0);
        #1;
        rst_n = 1'b1;
        tick();
        wb_vld = 1'b1; wb_idx = 5'd12;
        tick();
        wb_vld = 1'b0;
        chk("post_rst_wb", pending, 32'h0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
